// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryption sequencing controller.
package aes_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_MSG,
      ST_KEY_WAIT,
      ST_ARK,
      ST_ISR,
      ST_ISB,
      ST_IMC,
      ST_DONE
   } aes_state_e;

   localparam logic [1:0] SEL_ARK = 2'b00;
   localparam logic [1:0] SEL_ISR = 2'b01;
   localparam logic [1:0] SEL_ISB = 2'b10;
   localparam logic [1:0] SEL_IMC = 2'b11;

   localparam int NUM_ROUNDS = 10;
   localparam int NUM_COLS   = 4;

endpackage

// File: rtl/aes_wait_cnt.sv
// Loadable 5-bit down-counter with zero flag; it parks at zero rather than wrapping.
module aes_wait_cnt (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [4:0] load_val,
   output logic [4:0] count,
   output logic       zero
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 5'd1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/aes_dec_ctrl.sv
// Sequencing controller for the AES-128 decryption datapath (mux selects, load enables, round-key index).
// Optional key reuse (skip KEY_WAIT when KEY_SAME=1) is enabled by defining AES_KEY_REUSE_EN.
module aes_dec_ctrl
   import aes_ctrl_pkg::*;
#(
   parameter int KEY_EXP_CYCLES = 11,
   parameter int SUB_LAT        = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       aes_start,
`ifdef AES_KEY_REUSE_EN
   input  logic       key_same,
`endif
   output logic       aes_done,
   output logic       busy,
   output logic       msg_ld,
   output logic [1:0] state_sel,
   output logic [1:0] col_sel,
   output logic       state_ld,
   output logic [3:0] round_idx
);

   aes_state_e state, next_state;
   logic [3:0] round_q, next_round;
   logic       cnt_load;
   logic [4:0] cnt_val;
   logic [4:0] cnt;
   logic       cnt_zero;
   logic       skip_key;

   aes_wait_cnt u_wait_cnt (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .count    (cnt),
      .zero     (cnt_zero)
   );

`ifdef AES_KEY_REUSE_EN
   // Key-reuse request is captured together with the start request so later toggling is ignored.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         skip_key <= 1'b0;
      end else if (state == ST_IDLE && aes_start) begin
         skip_key <= key_same;
      end
   end
`else
   assign skip_key = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         round_q <= 4'(NUM_ROUNDS);
      end else begin
         state   <= next_state;
         round_q <= next_round;
      end
   end

   // The wait counter is loaded on the edge that enters a multi-cycle step, so it reads N-1 on the first cycle.
   always_comb begin
      next_state = state;
      next_round = round_q;
      cnt_load   = 1'b0;
      cnt_val    = '0;
      case (state)
         ST_IDLE: begin
            if (aes_start) next_state = ST_LOAD_MSG;
         end
         ST_LOAD_MSG: begin
            if (skip_key) begin
               next_state = ST_ARK;
            end else begin
               next_state = ST_KEY_WAIT;
               cnt_load   = 1'b1;
               cnt_val    = 5'(KEY_EXP_CYCLES - 1);
            end
         end
         ST_KEY_WAIT: begin
            if (cnt_zero) next_state = ST_ARK;
         end
         ST_ARK: begin
            if (round_q == 4'(NUM_ROUNDS)) begin
               next_state = ST_ISR;
            end else if (round_q == 4'd0) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_IMC;
               cnt_load   = 1'b1;
               cnt_val    = 5'(NUM_COLS - 1);
            end
            if (round_q != 4'd0) next_round = round_q - 4'd1;
         end
         ST_ISR: begin
            next_state = ST_ISB;
            cnt_load   = 1'b1;
            cnt_val    = 5'(SUB_LAT - 1);
         end
         ST_ISB: begin
            if (cnt_zero) next_state = ST_ARK;
         end
         ST_IMC: begin
            if (cnt_zero) next_state = ST_ISR;
         end
         ST_DONE: begin
            if (!aes_start) begin
               next_state = ST_IDLE;
               next_round = 4'(NUM_ROUNDS);
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Outputs decode only registered state, so no input reaches an output combinationally.
   always_comb begin
      aes_done  = (state == ST_DONE);
      busy      = (state != ST_IDLE) && (state != ST_DONE);
      msg_ld    = (state == ST_LOAD_MSG);
      state_sel = SEL_ARK;
      col_sel   = 2'd0;
      state_ld  = 1'b0;
      round_idx = round_q;
      case (state)
         ST_ARK: begin
            state_sel = SEL_ARK;
            state_ld  = 1'b1;
         end
         ST_ISR: begin
            state_sel = SEL_ISR;
            state_ld  = 1'b1;
         end
         ST_ISB: begin
            state_sel = SEL_ISB;
            state_ld  = cnt_zero;
         end
         ST_IMC: begin
            state_sel = SEL_IMC;
            state_ld  = 1'b1;
            col_sel   = 2'(5'(NUM_COLS - 1) - cnt);
         end
         default: begin
            state_sel = SEL_ARK;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Self-checking bench for aes_dec_ctrl: vector table, trace model of a full decryption run, corner sequences.
// Two instances: default parameters, and KEY_EXP_CYCLES=4 / SUB_LAT=3.
module tb_aes_dec_ctrl;

   typedef struct packed {
      logic       done;
      logic       busy;
      logic       msg;
      logic [1:0] sel;
      logic [1:0] col;
      logic       ld;
      logic [3:0] rnd;
   } obs_t;

   typedef struct {
      logic rst_n;
      logic start;
      obs_t expv;
   } vec_t;

   logic       clk;
   logic       rst_n     [2];
   logic       start_w   [2];
`ifdef AES_KEY_REUSE_EN
   logic       ksame     [2];
`endif
   logic       done_w    [2];
   logic       busy_w    [2];
   logic       msg_w     [2];
   logic [1:0] sel_w     [2];
   logic [1:0] col_w     [2];
   logic       ld_w      [2];
   logic [3:0] rnd_w     [2];

   int   tests = 0;
   int   fails = 0;
   obs_t exp_q[$];
   vec_t vecs[7];

   aes_dec_ctrl dut0 (
      .clk       (clk),
      .reset_n   (rst_n[0]),
      .aes_start (start_w[0]),
`ifdef AES_KEY_REUSE_EN
      .key_same  (ksame[0]),
`endif
      .aes_done  (done_w[0]),
      .busy      (busy_w[0]),
      .msg_ld    (msg_w[0]),
      .state_sel (sel_w[0]),
      .col_sel   (col_w[0]),
      .state_ld  (ld_w[0]),
      .round_idx (rnd_w[0])
   );

   aes_dec_ctrl #(.KEY_EXP_CYCLES(4), .SUB_LAT(3)) dut1 (
      .clk       (clk),
      .reset_n   (rst_n[1]),
      .aes_start (start_w[1]),
`ifdef AES_KEY_REUSE_EN
      .key_same  (ksame[1]),
`endif
      .aes_done  (done_w[1]),
      .busy      (busy_w[1]),
      .msg_ld    (msg_w[1]),
      .state_sel (sel_w[1]),
      .col_sel   (col_w[1]),
      .state_ld  (ld_w[1]),
      .round_idx (rnd_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int kexp_of(int id);
      return (id == 0) ? 11 : 4;
   endfunction

   function automatic int slat_of(int id);
      return (id == 0) ? 1 : 3;
   endfunction

   function automatic obs_t mk(logic done, logic busy, logic msg, logic [1:0] sel,
                               logic [1:0] col, logic ld, int rnd);
      obs_t o;
      o.done = done;
      o.busy = busy;
      o.msg  = msg;
      o.sel  = sel;
      o.col  = col;
      o.ld   = ld;
      o.rnd  = 4'(rnd);
      return o;
   endfunction

   function automatic obs_t get_obs(int id);
      return mk(done_w[id], busy_w[id], msg_w[id], sel_w[id], col_w[id], ld_w[id], int'(rnd_w[id]));
   endfunction

   function automatic string fmt(obs_t o);
      return $sformatf("done=%0b busy=%0b msg_ld=%0b sel=%0d col=%0d ld=%0b round=%0d",
                       o.done, o.busy, o.msg, o.sel, o.col, o.ld, o.rnd);
   endfunction

   // Expected per-cycle outputs of one run, starting with the LOAD_MSG cycle and ending at the first DONE cycle.
   function automatic void build_run(int kexp, int slat, bit skip);
      exp_q.delete();
      exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 10));
      if (!skip)
         for (int i = 0; i < kexp; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 10));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 10));
      for (int r = 9; r >= 0; r--) begin
         exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd1, 2'd0, 1'b1, r));
         for (int s = 0; s < slat; s++)
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd2, 2'd0, (s == slat - 1), r));
         exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, r));
         if (r > 0)
            for (int c = 0; c < 4; c++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 2'd3, 2'(c), 1'b1, r - 1));
      end
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 0));
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_output(string name, obs_t act, obs_t expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %s, expected %s", name, fmt(act), fmt(expv));
      end
   endtask

   task automatic check_int(string name, int act, int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic apply_stimulus(vec_t v);
      rst_n[0]   = v.rst_n;
      rst_n[1]   = v.rst_n;
      start_w[0] = v.start;
      tick();
   endtask

   // One full run: per-cycle trace compare, then latency, load-pulse count, ARK key order and DONE handshake.
   task automatic run_check(int id, bit skip, int exp_lat, int hold_fixed);
      int cyc;
      int lat;
      int ld_cnt;
      int hold;
      int arks[$];
      obs_t o;
      build_run(kexp_of(id), slat_of(id), skip);
      start_w[id] = 1'b1;
`ifdef AES_KEY_REUSE_EN
      ksame[id] = skip;
`endif
      tick();
      cyc    = 0;
      lat    = -1;
      ld_cnt = 0;
      while (cyc < 300) begin
         o = get_obs(id);
         if (cyc < exp_q.size()) check_output($sformatf("run%0d cyc%0d", id, cyc), o, exp_q[cyc]);
         if (o.ld === 1'b1) begin
            ld_cnt++;
            if (o.sel == 2'd0) arks.push_back(int'(o.rnd));
         end
         if (o.done === 1'b1) begin
            lat = cyc;
            break;
         end
         start_w[id] = 1'($urandom_range(0, 1));
`ifdef AES_KEY_REUSE_EN
         ksame[id] = 1'($urandom_range(0, 1));
`endif
         tick();
         cyc++;
      end
      check_int($sformatf("run%0d latency", id), lat, exp_lat);
      check_int($sformatf("run%0d state_ld pulses", id), ld_cnt, 67);
      check_int($sformatf("run%0d ark count", id), arks.size(), 11);
      for (int i = 0; i < arks.size() && i < 11; i++)
         check_int($sformatf("run%0d ark%0d round", id, i), arks[i], 10 - i);
      if (lat < 0) begin
         rst_n[id]   = 1'b0;
         start_w[id] = 1'b0;
         tick();
         rst_n[id] = 1'b1;
      end else begin
         hold = (hold_fixed > 0) ? hold_fixed : int'($urandom_range(1, 20));
         start_w[id] = 1'b1;
         for (int i = 0; i < hold; i++) begin
            tick();
            check_output($sformatf("run%0d done hold %0d", id, i), get_obs(id),
                         mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 0));
         end
         start_w[id] = 1'b0;
         tick();
         check_output($sformatf("run%0d back to idle", id), get_obs(id),
                      mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 10));
      end
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
   endtask

   task automatic reset_mid_run();
      int k;
      build_run(11, 1, 1'b0);
      k = -1;
      foreach (exp_q[i])
         if (k < 0 && exp_q[i].sel == 2'd3 && exp_q[i].col == 2'd2 && exp_q[i].rnd == 4'd4) k = i;
      start_w[0] = 1'b1;
      tick();
      start_w[0] = 1'b0;
      for (int i = 0; i < k; i++) tick();
      check_output("pre-reset round5 imc col2", get_obs(0), exp_q[k]);
      rst_n[0] = 1'b0;
      tick();
      check_output("mid-run reset", get_obs(0), mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 10));
      rst_n[0] = 1'b1;
      tick();
      check_output("idle after reset", get_obs(0), mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 10));
   endtask

   initial begin
      rst_n[0]   = 1'b0;
      rst_n[1]   = 1'b0;
      start_w[0] = 1'b0;
      start_w[1] = 1'b0;
`ifdef AES_KEY_REUSE_EN
      ksame[0] = 1'b0;
      ksame[1] = 1'b0;
`endif
      vecs[0] = '{1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 10)};
      vecs[1] = '{1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 10)};
      vecs[2] = '{1'b1, 1'b1, mk(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0, 10)};
      vecs[3] = '{1'b1, 1'b0, mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 10)};
      vecs[4] = '{1'b1, 1'b1, mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 10)};
      vecs[5] = '{1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 10)};
      vecs[6] = '{1'b1, 1'b0, mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 10)};

      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         apply_stimulus(vecs[i]);
         check_output($sformatf("vector %0d", i), get_obs(0), vecs[i].expv);
      end
      check_output("inst1 reset state", get_obs(1), mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 10));

      run_check(0, 1'b0, 79, 20);
      run_check(0, 1'b0, 79, 0);
      run_check(1, 1'b0, 92, 0);
      reset_mid_run();
      run_check(0, 1'b0, 79, 0);
`ifdef AES_KEY_REUSE_EN
      run_check(0, 1'b1, 68, 0);
      run_check(0, 1'b0, 79, 0);
      run_check(1, 1'b1, 88, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
